// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 3-input gate through all 8 input rows
// and rebuilds its 8-bit truth-table code from the sampled output.

module truth_table_sweeper #(
  // Cycles each row is held before the first sample; legal 1..255
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       drv_in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_code,
  output logic       match,
  output logic       unstable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE_A,
    S_SAMPLE_B,
    S_DONE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] exp_q, exp_d;
  logic       samp_a_q, samp_a_d;
  logic       acc_q, acc_d;
  logic [7:0] code_q, code_d;
  logic       match_q, match_d;
  logic       unst_q, unst_d;

  logic [7:0] shadow_wr;
  logic       acc_wr;

  // Shadow code and unstable flag with the current row's B sample merged in
  always_comb begin
    shadow_wr = shadow_q;
    shadow_wr[3'd7 - idx_q] = dut_out;
    acc_wr = acc_q | (dut_out ^ samp_a_q);
  end

  // Next-state logic: settle, double-sample, advance row, publish on the last row
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    exp_d    = exp_q;
    samp_a_d = samp_a_q;
    acc_d    = acc_q;
    code_d   = code_q;
    match_d  = match_q;
    unst_d   = unst_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d    = expected;
          idx_d    = 3'd0;
          cnt_d    = 8'd0;
          shadow_d = 8'h00;
          acc_d    = 1'b0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE_A;
        end
      end
      S_SAMPLE_A: begin
        samp_a_d = dut_out;
        state_d  = S_SAMPLE_B;
      end
      S_SAMPLE_B: begin
        shadow_d = shadow_wr;
        acc_d    = acc_wr;
        if (idx_q == 3'd7) begin
          code_d  = shadow_wr;
          match_d = (shadow_wr == exp_q);
          unst_d  = acc_wr;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = 8'd0;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        idx_d   = 3'd0;
        state_d = S_IDLE;
      end
      default: begin
        idx_d   = 3'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts a sweep without publishing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      cnt_q    <= 8'd0;
      shadow_q <= 8'h00;
      exp_q    <= 8'h00;
      samp_a_q <= 1'b0;
      acc_q    <= 1'b0;
      code_q   <= 8'h00;
      match_q  <= 1'b0;
      unst_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      exp_q    <= exp_d;
      samp_a_q <= samp_a_d;
      acc_q    <= acc_d;
      code_q   <= code_d;
      match_q  <= match_d;
      unst_q   <= unst_d;
    end
  end

  // Drives follow the row index; status comes straight from state and result flops
  always_comb begin
    {drv_in1, drv_in2, drv_in3} = idx_q;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    table_code = code_q;
    match      = match_q;
    unstable   = unst_q;
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: two sweepers (settle 4 and 1) driving gate models,
// checked each cycle against a row/phase arithmetic model plus literal results.

module tb_truth_table_sweeper;

  localparam int NI = 2;
  localparam int S0 = 4;
  localparam int S1 = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NI-1:0] start;
  logic [7:0]    expected;
  logic [NI-1:0] dut_out;
  logic [NI-1:0] d1, d2, d3;
  logic [NI-1:0] busy, done, match, unst;
  logic [7:0]    code [NI];

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.SETTLE_CYCLES(S0)) u_s4 (
    .clk(clk), .reset(reset), .start(start[0]),
    .expected(expected), .dut_out(dut_out[0]),
    .drv_in1(d1[0]), .drv_in2(d2[0]), .drv_in3(d3[0]),
    .busy(busy[0]), .done(done[0]), .table_code(code[0]),
    .match(match[0]), .unstable(unst[0])
  );

  truth_table_sweeper #(.SETTLE_CYCLES(S1)) u_s1 (
    .clk(clk), .reset(reset), .start(start[1]),
    .expected(expected), .dut_out(dut_out[1]),
    .drv_in1(d1[1]), .drv_in2(d2[1]), .drv_in3(d3[1]),
    .busy(busy[1]), .done(done[1]), .table_code(code[1]),
    .match(match[1]), .unstable(unst[1])
  );

  function automatic int sc(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic int lim(input int i);
    return 8 * (sc(i) + 2);
  endfunction

  // Gate models: truth-table lookup with N-cycle delay, or a free toggler
  logic [7:0]    gfunc [NI];
  int            gdel [NI];
  logic [NI-1:0] gtog;
  logic [NI-1:0] tog;
  logic [2:0]    hist [NI][4];
  logic [2:0]    gr [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        tog[i] <= 1'b0;
        for (int k = 0; k < 4; k++) hist[i][k] <= 3'd0;
      end else begin
        tog[i] <= ~tog[i];
        hist[i][0] <= {d1[i], d2[i], d3[i]};
        for (int k = 1; k < 4; k++) hist[i][k] <= hist[i][k-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      gr[i] = {d1[i], d2[i], d3[i]};
      if (gdel[i] > 0) gr[i] = hist[i][gdel[i]-1];
      dut_out[i] = gtog[i] ? tog[i] : gfunc[i][3'd7 - gr[i]];
    end
  end

  // Reference model: cycle t after acceptance is row t/(S+2), phase t%(S+2)
  logic [NI-1:0] m_act, m_sa, m_acc, m_match, m_unst;
  int            m_t [NI];
  logic [7:0]    m_exp [NI];
  logic [7:0]    m_sh [NI];
  logic [7:0]    m_code [NI];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_act[i] <= 1'b0; m_sa[i] <= 1'b0; m_acc[i] <= 1'b0;
        m_match[i] <= 1'b0; m_unst[i] <= 1'b0; m_t[i] <= 0;
        m_exp[i] <= 8'h00; m_sh[i] <= 8'h00; m_code[i] <= 8'h00;
      end else if (!m_act[i]) begin
        if (start[i]) begin
          m_act[i] <= 1'b1; m_t[i] <= 0; m_exp[i] <= expected;
          m_sh[i] <= 8'h00; m_acc[i] <= 1'b0;
        end
      end else begin
        if (m_t[i] < lim(i) && m_t[i] % (sc(i) + 2) == sc(i))
          m_sa[i] <= dut_out[i];
        if (m_t[i] < lim(i) && m_t[i] % (sc(i) + 2) == sc(i) + 1) begin
          m_sh[i][7 - m_t[i] / (sc(i) + 2)] <= dut_out[i];
          if (dut_out[i] != m_sa[i]) m_acc[i] <= 1'b1;
        end
        m_t[i] <= m_t[i] + 1;
        if (m_t[i] + 1 == lim(i)) begin
          m_code[i]  <= {m_sh[i][7:1], dut_out[i]};
          m_match[i] <= ({m_sh[i][7:1], dut_out[i]} == m_exp[i]);
          m_unst[i]  <= m_acc[i] | (dut_out[i] != m_sa[i]);
        end
        if (m_t[i] + 1 == lim(i) + 1) m_act[i] <= 1'b0;
      end
    end
  end

  function automatic logic [2:0] prow(input int i);
    if (!m_act[i]) return 3'd0;
    if (m_t[i] < lim(i)) return 3'(m_t[i] / (sc(i) + 2));
    return 3'd7;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    end
  endtask

  function automatic logic [14:0] dut_vec(input int i);
    return {busy[i], done[i], d1[i], d2[i], d3[i], code[i], match[i], unst[i]};
  endfunction

  // Every clock: all outputs of both sweepers against the model
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("cycle_i%0d", i), 32'(dut_vec(i)),
            32'({m_act[i], m_act[i] && (m_t[i] == lim(i)), prow(i),
                 m_code[i], m_match[i], m_unst[i]}));
    end
  endtask

  // mode 0: quiet, 1: random start/expected noise, 2: start pulses at edges 10/30
  task automatic sweep(input int i, input logic [7:0] exp, input int mode,
                       output int edges, output logic [7:0] c,
                       output logic m, output logic u);
    expected = exp;
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    edges = -1;
    for (int n = 0; n < 4000; n++) begin
      if (done[i]) begin
        edges = n;
        break;
      end
      if (mode == 1) begin
        start[i] = ($urandom_range(0, 3) == 0);
        expected = 8'($urandom);
      end else if (mode == 2) begin
        start[i] = (n == 9 || n == 29);
      end
      tick();
    end
    start[i] = 1'b0;
    c = code[i];
    m = match[i];
    u = unst[i];
    tick();
  endtask

  task automatic sweep_check(input string nm, input int i,
                             input logic [7:0] exp, input int mode,
                             input logic [7:0] wc, input logic wu);
    int e;
    logic [7:0] c;
    logic m, u;
    sweep(i, exp, mode, e, c, m, u);
    check({nm, "_edges"}, 32'(e), 32'(lim(i)));
    check({nm, "_code"}, 32'(c), 32'(wc));
    check({nm, "_match"}, 32'(m), 32'(wc == exp));
    check({nm, "_unstable"}, 32'(u), 32'(wu));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int e, first_done, second_done, dcount, ri;
    logic [7:0] c, rf, re;
    logic m, u;
    start = '0;
    expected = 8'h00;
    gtog = '0;
    for (int i = 0; i < NI; i++) begin
      gfunc[i] = 8'h00;
      gdel[i] = 0;
    end
    repeat (3) tick();
    check("reset_state", 32'(dut_vec(0)), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    gfunc[0] = 8'h20;
    sweep_check("row010_gate", 0, 8'h20, 0, 8'h20, 1'b0);
    gfunc[0] = 8'h7F;
    sweep_check("or3_gate", 0, 8'h20, 0, 8'h7F, 1'b0);

    gfunc[0] = 8'h20; gdel[0] = 3;
    repeat (4) tick();
    sweep_check("delay3_s4", 0, 8'h20, 0, 8'h20, 1'b0);
    gdel[0] = 0;
    gfunc[1] = 8'h20; gdel[1] = 3;
    repeat (4) tick();
    sweep_check("delay3_s1", 1, 8'h20, 0, 8'h10, 1'b0);
    gdel[1] = 0;

    gtog[0] = 1'b1;
    sweep(0, 8'h00, 0, e, c, m, u);
    check("toggle_edges", 32'(e), 32'd48);
    check("toggle_unstable", 32'(u), 32'd1);
    check("toggle_code_uniform", 32'(c == 8'h00 || c == 8'hFF), 32'd1);
    gtog[0] = 1'b0;

    gfunc[0] = 8'h7F;
    sweep_check("pre_reset", 0, 8'h7F, 0, 8'h7F, 1'b0);
    expected = 8'h7F;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (32) tick();
    check("row5_drive", 32'({busy[0], d1[0], d2[0], d3[0]}), 32'({1'b1, 3'd5}));
    #1 reset = 1'b1;
    #1 check("async_reset_clear", 32'(dut_vec(0)), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    dcount = 0;
    repeat (60) begin
      tick();
      if (done[0]) dcount++;
    end
    check("no_done_after_reset", 32'(dcount), 32'd0);
    sweep_check("after_reset", 0, 8'h7F, 0, 8'h7F, 1'b0);

    gfunc[0] = 8'h96;
    sweep_check("start_pulses_ignored", 0, 8'h96, 2, 8'h96, 1'b0);

    gfunc[0] = 8'h3C;
    expected = 8'h3C;
    start[0] = 1'b1;
    tick();
    first_done = -1;
    second_done = -1;
    for (int n = 0; n < 300; n++) begin
      if (done[0]) begin
        if (first_done < 0) first_done = n;
        else if (n != first_done) begin
          second_done = n;
          break;
        end
      end
      tick();
    end
    start[0] = 1'b0;
    tick();
    check("held_first_done", 32'(first_done), 32'd48);
    check("held_second_done", 32'(second_done), 32'd98);
    check("held_code", 32'(code[0]), 32'h3C);

    for (int k = 0; k < 16; k++) begin
      ri = int'($urandom_range(0, 1));
      rf = 8'($urandom);
      re = ($urandom_range(0, 1) == 1) ? rf : 8'($urandom);
      gfunc[ri] = rf;
      gdel[ri] = (ri == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1));
      repeat (4) tick();
      sweep_check($sformatf("rand%0d", k), ri, re, 1, rf, 1'b0);
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
